// File: rtl/lz77_encoder.sv
// Streaming LZ77 encoder emitting (code_pos, code_len, char_nxt) tokens, valid held code_len+1 cycles.
// Optional LZ77_ENC_EARLY_EXIT_EN ends SEARCH as soon as a candidate reaches the length limit.
module lz77_encoder #(
  parameter int SEARCH_DEPTH = 30,
  parameter int LA_DEPTH     = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       char_valid,
  input  logic [7:0] chardata,
  output logic       char_ready,
  output logic       valid,
  output logic       encode,
  output logic [4:0] code_pos,
  output logic [4:0] code_len,
  output logic [7:0] char_nxt,
  output logic       finish
);

  localparam int HW  = (SEARCH_DEPTH > 1) ? $clog2(SEARCH_DEPTH) : 1;
  localparam int LW  = $clog2(LA_DEPTH);
  localparam int CW  = $clog2(LA_DEPTH + 1);
  localparam int HCW = $clog2(SEARCH_DEPTH + 1);
  localparam logic [7:0] EOS = 8'h24;

  typedef enum logic [1:0] {FILL, SEARCH, EMIT, DONE} state_t;
  state_t state, next_state;

  logic [7:0]     hist [SEARCH_DEPTH];
  logic [7:0]     la   [LA_DEPTH];
  logic [CW-1:0]  la_cnt;
  logic [HCW-1:0] hist_cnt;
  logic           eos_seen;
  logic [4:0]     pos, best_pos, best_len, emit_cnt;
  logic [4:0]     cand_len, lim, fin_pos, fin_len;
  logic [7:0]     src;
  logic           run, cand_ok, take, search_end, accept;

  // Candidate match length at distance pos+1 over the window {history, lookahead}.
  always_comb begin
    lim      = (la_cnt > CW'(LA_DEPTH - 1)) ? 5'(LA_DEPTH - 1) : 5'(la_cnt - 1'b1);
    cand_len = '0;
    run      = 1'b1;
    src      = '0;
    for (int j = 0; j < LA_DEPTH - 1; j++) begin
      if (run && (j < int'(lim))) begin
        if (j > int'(pos)) src = la[LW'(j - int'(pos) - 1)];
        else               src = hist[HW'(int'(pos) - j)];
        if (la[LW'(j)] == src) cand_len = 5'(j + 1);
        else                   run = 1'b0;
      end
    end
    cand_ok = int'(pos) < int'(hist_cnt);
    take    = cand_ok && (cand_len > best_len);
    fin_len = take ? cand_len : best_len;
    fin_pos = take ? pos : best_pos;
`ifdef LZ77_ENC_EARLY_EXIT_EN
    search_end = (pos == 5'(SEARCH_DEPTH - 1)) || (cand_ok && (cand_len == lim));
`else
    search_end = (pos == 5'(SEARCH_DEPTH - 1));
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FILL;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    char_ready = 1'b0;
    valid      = 1'b0;
    case (state)
      FILL: begin
        // encode doubles as the "out of reset" qualifier so char_ready is 0 during reset.
        char_ready = encode && !eos_seen && (la_cnt < CW'(LA_DEPTH));
        if (eos_seen || (la_cnt == CW'(LA_DEPTH))) next_state = SEARCH;
      end
      SEARCH: if (search_end) next_state = EMIT;
      EMIT: begin
        valid = 1'b1;
        if (emit_cnt == code_len) next_state = (char_nxt == EOS) ? DONE : FILL;
      end
      DONE:    next_state = DONE;
      default: next_state = FILL;
    endcase
  end

  assign accept = (state == FILL) && char_valid && char_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      encode   <= 1'b0;
      finish   <= 1'b0;
      code_pos <= '0;
      code_len <= '0;
      char_nxt <= '0;
      la_cnt   <= '0;
      hist_cnt <= '0;
      eos_seen <= 1'b0;
      pos      <= '0;
      best_pos <= '0;
      best_len <= '0;
      emit_cnt <= '0;
    end else begin
      encode <= 1'b1;
      case (state)
        FILL: begin
          if (accept) begin
            la_cnt <= la_cnt + 1'b1;
            if (chardata == EOS) eos_seen <= 1'b1;
          end
          pos      <= '0;
          best_pos <= '0;
          best_len <= '0;
        end
        SEARCH: begin
          pos      <= pos + 1'b1;
          best_pos <= fin_pos;
          best_len <= fin_len;
          if (search_end) begin
            code_pos <= fin_pos;
            code_len <= fin_len;
            char_nxt <= la[LW'(fin_len)];
            emit_cnt <= '0;
          end
        end
        EMIT: begin
          emit_cnt <= emit_cnt + 1'b1;
          la_cnt   <= la_cnt - 1'b1;
          if (hist_cnt < HCW'(SEARCH_DEPTH)) hist_cnt <= hist_cnt + 1'b1;
          if (next_state == DONE) finish <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Byte storage needs no reset: occupancy counters define what is live.
  always_ff @(posedge clk) begin
    if (accept) begin
      la[LW'(la_cnt)] <= chardata;
    end else if (state == EMIT) begin
      hist[0] <= la[0];
      for (int i = 1; i < SEARCH_DEPTH; i++) hist[i] <= hist[i-1];
      for (int i = 0; i < LA_DEPTH - 1; i++) la[i] <= la[i+1];
    end
  end

endmodule

// File: tb/tb_lz77_encoder.sv
// Directed self-checking bench for lz77_encoder: token sequences, finish timing, mid-EMIT reset.
module tb_lz77_encoder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       char_valid = 1'b0;
  logic [7:0] chardata = '0;
  logic       char_ready, valid, encode, finish;
  logic [4:0] code_pos, code_len;
  logic [7:0] char_nxt;

  lz77_encoder dut (
    .clk(clk), .reset(reset), .char_valid(char_valid), .chardata(chardata),
    .char_ready(char_ready), .valid(valid), .encode(encode), .code_pos(code_pos),
    .code_len(code_len), .char_nxt(char_nxt), .finish(finish)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] pos;
    logic [4:0] len;
    logic [7:0] nxt;
    int         cyc;
  } tok_t;

  tok_t tok_q[$];
  int   gap_q[$];
  tok_t cur;
  int   checks = 0, passes = 0;
  int   cyc = 0, tot_valid = 0, idle = 0, run_len = 0;
  int   last_valid_cyc = 0, fin_cyc = 0;
  bit   in_tok = 0, fin_seen = 0, unstable = 0, abort = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!reset) begin
      in_tok = 0; fin_seen = 0; run_len = 0; idle = 0;
    end else begin
      if (valid) begin
        if (!in_tok) begin
          in_tok = 1; run_len = 1;
          cur.pos = code_pos; cur.len = code_len; cur.nxt = char_nxt;
          gap_q.push_back(idle); idle = 0;
        end else begin
          run_len++;
          if ({code_pos, code_len, char_nxt} !== {cur.pos, cur.len, cur.nxt}) unstable = 1;
        end
        tot_valid++; last_valid_cyc = cyc;
      end else begin
        idle++;
        if (in_tok) begin
          in_tok = 0; cur.cyc = run_len; tok_q.push_back(cur);
        end
      end
      if (finish && !fin_seen) begin fin_seen = 1; fin_cyc = cyc; end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_tok(input string tag, input int idx, input logic [4:0] p,
                         input logic [4:0] l, input logic [7:0] n, input int c);
    logic [63:0] obs;
    obs = '1;
    if (idx < tok_q.size())
      obs = {30'd0, tok_q[idx].pos, tok_q[idx].len, tok_q[idx].nxt, 16'(tok_q[idx].cyc)};
    chk(tag, obs, {30'd0, p, l, n, 16'(c)});
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0; abort = 0; char_valid = 1'b0;
    tok_q.delete(); gap_q.delete(); tot_valid = 0; unstable = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic send(input string s);
    for (int i = 0; i < s.len() && !abort; i++) begin
      int n = 0;
      char_valid = 1'b1;
      chardata   = s[i];
      @(negedge clk);
      while (!char_ready && n < 500 && !abort) begin @(negedge clk); n++; end
      if (n >= 500) chk("send_timeout", 0, 1);
      if (!abort) begin @(posedge clk); #1; end
    end
    char_valid = 1'b0;
  endtask

  task automatic wait_finish(input string tag);
    int n = 0;
    while (!finish && n < 3000) begin @(negedge clk); n++; end
    chk(tag, finish, 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_valid", valid, 0);
    chk("rst_encode", encode, 0);
    chk("rst_finish", finish, 0);
    chk("rst_ready", char_ready, 0);
    chk("rst_fields", {code_pos, code_len, char_nxt}, 0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    chk("encode_up", encode, 1);

    // 1: "A$"
    send("A$");
    wait_finish("t1_finish");
    chk("t1_ntok", tok_q.size(), 2);
    chk_tok("t1_tok0", 0, 5'd0, 5'd0, 8'h41, 1);
    chk_tok("t1_tok1", 1, 5'd0, 5'd0, 8'h24, 1);
    chk("t1_fin_timing", fin_cyc, last_valid_cyc + 1);
    repeat (5) @(negedge clk);
    chk("t1_fin_sticky", finish, 1);
    chk("t1_ready_done", char_ready, 0);

    // 2: "AAAA$"
    do_reset();
    send("AAAA$");
    wait_finish("t2_finish");
    chk("t2_ntok", tok_q.size(), 2);
    chk_tok("t2_tok0", 0, 5'd0, 5'd0, 8'h41, 1);
    chk_tok("t2_tok1", 1, 5'd0, 5'd3, 8'h24, 4);

    // 3: "ABCABC$"
    do_reset();
    send("ABCABC$");
    wait_finish("t3_finish");
    chk("t3_ntok", tok_q.size(), 4);
    chk_tok("t3_tok0", 0, 5'd0, 5'd0, 8'h41, 1);
    chk_tok("t3_tok1", 1, 5'd0, 5'd0, 8'h42, 1);
    chk_tok("t3_tok2", 2, 5'd0, 5'd0, 8'h43, 1);
    chk_tok("t3_tok3", 3, 5'd2, 5'd3, 8'h24, 4);

    // 4/6: twenty 'x' then '$'
    do_reset();
    send("xxxxxxxxxxxxxxxxxxxx$");
    wait_finish("t4_finish");
    chk("t4_ntok", tok_q.size(), 3);
    chk_tok("t4_tok0", 0, 5'd0, 5'd0, 8'h78, 1);
    chk_tok("t4_tok1", 1, 5'd0, 5'd15, 8'h78, 16);
    chk_tok("t4_tok2", 2, 5'd0, 5'd3, 8'h24, 4);
    chk("t4_tot_valid", tot_valid, 21);
    chk("t4_stable", unstable, 0);
`ifdef LZ77_ENC_EARLY_EXIT_EN
    chk("t6_gap_short", (gap_q.size() > 1) && (gap_q[1] < 30), 1);
`else
    chk("t6_gap_full", (gap_q.size() > 1) && (gap_q[1] >= 31) && (gap_q[1] <= 33), 1);
`endif

    // 5: reset in the middle of the 16-cycle token, then "A$"
    do_reset();
    fork
      send("xxxxxxxxxxxxxxxxxxxx$");
      begin
        int nv = 0, n = 0;
        while (nv < 6 && n < 2000) begin @(negedge clk); n++; if (valid) nv++; end
        chk("t5_mid_emit", valid, 1);
        abort = 1;
        reset = 1'b0;
      end
    join
    #1;
    chk("t5_rst_valid", valid, 0);
    chk("t5_rst_encode", encode, 0);
    chk("t5_rst_fields", {code_pos, code_len, char_nxt, finish, char_ready}, 0);
    do_reset();
    send("A$");
    wait_finish("t5_finish");
    chk("t5_ntok", tok_q.size(), 2);
    chk_tok("t5_tok0", 0, 5'd0, 5'd0, 8'h41, 1);
    chk_tok("t5_tok1", 1, 5'd0, 5'd0, 8'h24, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
